// File: rtl/trace_log_buffer.sv
// trace_log_buffer: selects one of N_CH sample channels and records its valid
// samples into an internal RAM, either as a single-shot fill (mode 0) or as a
// circular pre-trigger capture with a programmable post-trigger count (mode 1).
// Captured entries are read back oldest-first, one entry per i_rd_next.
//
// Ports:
//   clock        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_data       N_CH packed samples, channel k at [k*NB_DATA +: NB_DATA]
//   i_valid      store the current sample of the selected channel
//   i_sel        channel select (latched at arm; out-of-range selects 0)
//   i_mode       0 = single-shot, 1 = circular with trigger (latched at arm)
//   i_post_count samples stored after the trigger sample (latched at arm)
//   i_arm        start / restart a capture
//   i_trigger    trigger event, mode 1 only
//   i_rd_next    request next captured entry (DONE only)
//   o_rd_data    readout data, held between pulses
//   o_rd_valid   one-cycle pulse qualifying o_rd_data
//   o_full       capture complete, data available for readout
//   o_busy       capture in progress
//   o_wrapped    write pointer wrapped during this capture
//   o_count      valid entries, saturating at DEPTH
module trace_log_buffer #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_ADDR = 10,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned NB_SEL  = 2
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic [N_CH*NB_DATA-1:0] i_data,
  input  logic                    i_valid,
  input  logic [NB_SEL-1:0]       i_sel,
  input  logic                    i_mode,
  input  logic [NB_ADDR-1:0]      i_post_count,
  input  logic                    i_arm,
  input  logic                    i_trigger,
  input  logic                    i_rd_next,
  output logic [NB_DATA-1:0]      o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_full,
  output logic                    o_busy,
  output logic                    o_wrapped,
  output logic [NB_ADDR:0]        o_count
);

  localparam int unsigned DEPTH  = 1 << NB_ADDR;
  localparam int unsigned NB_CNT = NB_ADDR + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NB_DATA-1:0]   r_mem [DEPTH];
  logic [NB_ADDR-1:0]   r_wr_ptr;
  logic [NB_CNT-1:0]    r_count;
  logic [NB_CNT-1:0]    r_rd_cnt;
  logic [NB_ADDR-1:0]   r_post;
  logic [NB_SEL-1:0]    r_sel;
  logic                 r_mode;
  logic                 r_wrapped;
  logic [NB_DATA-1:0]   r_rd_data;
  logic                 r_rd_valid;

  logic                 w_busy;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_rd_last;
  logic                 w_fill_last;
  logic [NB_ADDR-1:0]   w_rd_addr;
  logic [NB_DATA-1:0]   w_ch;

  // Selected channel sample
  always_comb begin
    w_ch = i_data[NB_DATA-1:0];
    for (int k = 1; k < N_CH; k++) begin
      if (r_sel == NB_SEL'(k)) w_ch = i_data[k*NB_DATA +: NB_DATA];
    end
  end

  // Arm and reset both suppress writes and reads in their cycle
  assign w_busy      = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_wr_en     = i_valid && w_busy && !i_arm && !i_reset;
  assign w_rd_en     = i_rd_next && (r_state == ST_DONE) && !i_arm && !i_reset;
  assign w_rd_last   = (r_rd_cnt + NB_CNT'(1)) >= r_count;
  assign w_fill_last = (r_count == NB_CNT'(DEPTH - 1));

  // Oldest entry sits at the write pointer once the buffer has wrapped
  assign w_rd_addr = (r_wrapped ? r_wr_ptr : '0) + r_rd_cnt[NB_ADDR-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_arm) begin
      w_state_nxt = ST_CAPTURE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_IDLE;
        ST_CAPTURE: begin
          if (!r_mode) begin
            if (w_wr_en && w_fill_last) w_state_nxt = ST_DONE;
          end else if (i_trigger) begin
            w_state_nxt = (r_post == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST:    if (w_wr_en && (r_post == NB_ADDR'(1))) w_state_nxt = ST_DONE;
        ST_DONE:    if (w_rd_en && w_rd_last) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    o_busy = 1'b0;
    o_full = 1'b0;
    case (r_state)
      ST_CAPTURE, ST_POST: o_busy = 1'b1;
      ST_DONE:             o_full = 1'b1;
      default:             ;
    endcase
  end

  // Sample RAM, not reset
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_ch;
  end

  // Pointers, counters, configuration and read port
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rd_cnt   <= '0;
      r_post     <= '0;
      r_sel      <= '0;
      r_mode     <= 1'b0;
      r_wrapped  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (i_arm) begin
        r_sel     <= (32'(i_sel) >= N_CH) ? '0 : i_sel;
        r_mode    <= i_mode;
        r_post    <= i_post_count;
        r_wr_ptr  <= '0;
        r_count   <= '0;
        r_rd_cnt  <= '0;
        r_wrapped <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + NB_ADDR'(1);
          // Single-shot stops on its wrapping write, so nothing is overwritten
          if (r_mode && (r_wr_ptr == NB_ADDR'(DEPTH - 1))) r_wrapped <= 1'b1;
          if (r_count != NB_CNT'(DEPTH)) r_count <= r_count + NB_CNT'(1);
          if (r_state == ST_POST) r_post <= r_post - NB_ADDR'(1);
        end
        if (w_rd_en) begin
          r_rd_data  <= r_mem[w_rd_addr];
          r_rd_valid <= 1'b1;
          r_rd_cnt   <= r_rd_cnt + NB_CNT'(1);
        end
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_wrapped  = r_wrapped;
  assign o_count    = r_count;

endmodule

// File: tb/tb_trace_log_buffer.sv
// Directed bench for trace_log_buffer with a readout scoreboard.
module tb_trace_log_buffer;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_ADDR = 4;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned NB_SEL  = 2;

  logic                    clock = 1'b0;
  logic                    i_reset;
  logic [N_CH*NB_DATA-1:0] i_data;
  logic                    i_valid;
  logic [NB_SEL-1:0]       i_sel;
  logic                    i_mode;
  logic [NB_ADDR-1:0]      i_post_count;
  logic                    i_arm;
  logic                    i_trigger;
  logic                    i_rd_next;
  logic [NB_DATA-1:0]      o_rd_data;
  logic                    o_rd_valid;
  logic                    o_full;
  logic                    o_busy;
  logic                    o_wrapped;
  logic [NB_ADDR:0]        o_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [NB_DATA-1:0] exp_q [$];

  trace_log_buffer #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_CH(N_CH), .NB_SEL(NB_SEL)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_sel(i_sel), .i_mode(i_mode), .i_post_count(i_post_count),
    .i_arm(i_arm), .i_trigger(i_trigger), .i_rd_next(i_rd_next),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_full(o_full),
    .o_busy(o_busy), .o_wrapped(o_wrapped), .o_count(o_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic set_sample(input int ch, input logic [7:0] val);
    i_data = {N_CH{8'hFF}};
    i_data[ch*NB_DATA +: NB_DATA] = val;
  endtask

  task automatic arm(input logic [NB_SEL-1:0] sel, input logic mode, input logic [NB_ADDR-1:0] post);
    i_sel = sel; i_mode = mode; i_post_count = post; i_arm = 1'b1;
    cyc();
    i_arm = 1'b0;
  endtask

  task automatic read_n(input int n);
    i_rd_next = 1'b1;
    repeat (n) cyc();
    i_rd_next = 1'b0;
  endtask

  // Scoreboard: every readout pulse must match the oldest expected entry
  always @(negedge clock) begin
    if (o_rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'(o_rd_valid), 32'd0);
      end else begin
        chk("rd_data", 32'(o_rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    i_reset = 1'b0; i_data = '0; i_valid = 1'b0; i_sel = '0; i_mode = 1'b0;
    i_post_count = '0; i_arm = 1'b0; i_trigger = 1'b0; i_rd_next = 1'b0;
    cyc();

    // Reset with random inputs
    i_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_data = $urandom; i_valid = 1'($urandom); i_sel = NB_SEL'($urandom);
      i_mode = 1'($urandom); i_post_count = NB_ADDR'($urandom);
      i_arm = 1'($urandom); i_trigger = 1'($urandom); i_rd_next = 1'($urandom);
      cyc();
    end
    i_reset = 1'b0; i_valid = 1'b0; i_arm = 1'b0; i_trigger = 1'b0; i_rd_next = 1'b0;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_wrapped", 32'(o_wrapped), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_rd_valid", 32'(o_rd_valid), 0);
    chk("rst_rd_data", 32'(o_rd_data), 0);

    // Single-shot fill from channel 2
    arm(2'd2, 1'b0, '0);
    chk("ss_busy_after_arm", 32'(o_busy), 1);
    chk("ss_count_after_arm", 32'(o_count), 0);
    i_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_sample(2, 8'(8'h20 + i));
      exp_q.push_back(8'(8'h20 + i));
      cyc();
      if (i == 14) chk("ss_full_before_last", 32'(o_full), 0);
    end
    i_valid = 1'b0;
    chk("ss_full", 32'(o_full), 1);
    chk("ss_busy", 32'(o_busy), 0);
    chk("ss_count", 32'(o_count), 16);
    chk("ss_wrapped", 32'(o_wrapped), 0);
    read_n(15);
    chk("ss_full_before_last_read", 32'(o_full), 1);
    read_n(1);
    chk("ss_full_after_readout", 32'(o_full), 0);
    chk("ss_busy_after_readout", 32'(o_busy), 0);
    cyc();
    chk("ss_rd_valid_drop", 32'(o_rd_valid), 0);
    chk("ss_rd_data_hold", 32'(o_rd_data), 32'h2F);
    read_n(1);
    chk("idle_rd_ignored", 32'(o_rd_valid), 0);
    chk("ss_queue_empty", 32'(exp_q.size()), 0);

    // Valid gaps: only even cycle indices stored
    arm(2'd1, 1'b0, '0);
    for (int i = 0; i < 32; i++) begin
      i_valid = ~i[0];
      set_sample(1, 8'(i));
      if (!i[0]) exp_q.push_back(8'(i));
      cyc();
    end
    i_valid = 1'b0;
    chk("gap_full", 32'(o_full), 1);
    chk("gap_count", 32'(o_count), 16);
    read_n(16);
    cyc();
    chk("gap_queue_empty", 32'(exp_q.size()), 0);

    // Circular capture, post count 3, trigger with sample 30
    arm(2'd0, 1'b1, 4'd3);
    i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_sample(0, 8'(i));
      i_trigger = (i == 30);
      cyc();
      if (i == 32) chk("circ_full_at_32", 32'(o_full), 0);
      if (i == 33) chk("circ_full_at_33", 32'(o_full), 1);
    end
    i_valid = 1'b0; i_trigger = 1'b0;
    chk("circ_wrapped", 32'(o_wrapped), 1);
    chk("circ_count", 32'(o_count), 16);
    for (int i = 18; i <= 33; i++) exp_q.push_back(8'(i));
    read_n(16);
    cyc();
    chk("circ_idle", 32'(o_full), 0);
    chk("circ_queue_empty", 32'(exp_q.size()), 0);

    // Circular capture, zero post count
    arm(2'd3, 1'b1, 4'd0);
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_sample(3, 8'(i));
      i_trigger = (i == 4);
      exp_q.push_back(8'(i));
      cyc();
    end
    i_valid = 1'b0; i_trigger = 1'b0;
    chk("zp_full", 32'(o_full), 1);
    chk("zp_count", 32'(o_count), 5);
    chk("zp_wrapped", 32'(o_wrapped), 0);
    read_n(5);
    cyc();
    chk("zp_queue_empty", 32'(exp_q.size()), 0);

    // Abort during readout, then arm coincident with trigger and valid
    arm(2'd0, 1'b0, '0);
    i_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_sample(0, 8'(8'h80 + i));
      if (i < 3) exp_q.push_back(8'(8'h80 + i));
      cyc();
    end
    i_valid = 1'b0;
    read_n(3);
    i_rd_next = 1'b1;
    arm(2'd0, 1'b1, 4'd2);
    i_rd_next = 1'b0;
    chk("abort_busy", 32'(o_busy), 1);
    chk("abort_full", 32'(o_full), 0);
    chk("abort_count", 32'(o_count), 0);
    chk("abort_no_rd_valid", 32'(o_rd_valid), 0);
    i_trigger = 1'b1; i_valid = 1'b1; set_sample(0, 8'hAA);
    arm(2'd0, 1'b1, 4'd2);
    i_trigger = 1'b0;
    chk("prio_busy", 32'(o_busy), 1);
    chk("prio_count", 32'(o_count), 0);
    for (int i = 0; i < 5; i++) begin
      set_sample(0, 8'(8'h50 + i));
      i_trigger = (i == 2);
      exp_q.push_back(8'(8'h50 + i));
      cyc();
    end
    i_valid = 1'b0; i_trigger = 1'b0;
    chk("prio_full", 32'(o_full), 1);
    chk("prio_final_count", 32'(o_count), 5);
    read_n(5);
    cyc();
    chk("prio_queue_empty", 32'(exp_q.size()), 0);

    // Reset while in POST
    arm(2'd1, 1'b1, 4'd5);
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sample(1, 8'(i));
      i_trigger = (i == 2);
      cyc();
    end
    i_trigger = 1'b0;
    chk("post_busy_before_reset", 32'(o_busy), 1);
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0; i_valid = 1'b0;
    chk("post_rst_busy", 32'(o_busy), 0);
    chk("post_rst_full", 32'(o_full), 0);
    chk("post_rst_count", 32'(o_count), 0);
    cyc();
    chk("post_rst_stays_idle", 32'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
